// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, RISC-V opcode constants
// used by the main decoder, and the load-use hazard rule.
package pipe_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MEMWAIT = 2'd2,
    ERROR   = 2'd3
  } hz_state_e;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_OP     = 7'b0110011,
    OPC_OPIMM  = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  // A load in EX feeds a source of the instruction in ID; x0 never hazards.
  function automatic logic load_use_hazard(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2
  );
    return mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline and the hazard controller.
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_if;
  import pipe_pkg::*;

  logic                   IDEX_MemRead_i;
  logic [REG_ADDR_W-1:0]  IDEX_Rd_i;
  logic [REG_ADDR_W-1:0]  IFID_Rs1_i;
  logic [REG_ADDR_W-1:0]  IFID_Rs2_i;
  logic                   Branch_taken_i;
  logic                   dmem_req_i;
  logic                   dmem_ack_i;

  logic                   PCWrite_o;
  logic                   IFIDWrite_o;
  logic                   IDEX_Bubble_o;
  logic                   IFID_Flush_o;
  logic                   Pipe_Hold_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;
  logic                   timeout_o;
  logic [1:0]             state_o;

  modport master (
    output IDEX_MemRead_i, IDEX_Rd_i, IFID_Rs1_i, IFID_Rs2_i,
           Branch_taken_i, dmem_req_i, dmem_ack_i,
    input  PCWrite_o, IFIDWrite_o, IDEX_Bubble_o, IFID_Flush_o,
           Pipe_Hold_o, stall_cnt_o, timeout_o, state_o
  );

  modport slave (
    input  IDEX_MemRead_i, IDEX_Rd_i, IFID_Rs1_i, IFID_Rs2_i,
           Branch_taken_i, dmem_req_i, dmem_ack_i,
    output PCWrite_o, IFIDWrite_o, IDEX_Bubble_o, IFID_Flush_o,
           Pipe_Hold_o, stall_cnt_o, timeout_o, state_o
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc,
  output logic [DATA_W-1:0] count
);

  // Count enabled cycles, holding at the maximum value.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + DATA_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory
// wait with timeout into a sticky error state, and a stalled-cycle counter.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave hz
);

  localparam int              WAIT_W     = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  hz_state_e          state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               timeout_q, timeout_d;

  logic mem_wait;
  logic load_use;
  logic pc_write, ifid_write, bubble, flush, hold;
  logic stall_inc;

  assign mem_wait = hz.dmem_req_i && !hz.dmem_ack_i;
  assign load_use = load_use_hazard(hz.IDEX_MemRead_i, hz.IDEX_Rd_i,
                                    hz.IFID_Rs1_i, hz.IFID_Rs2_i);

  // FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and control-output decode; reset forces no-stall outputs.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    timeout_d  = timeout_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    bubble     = 1'b0;
    flush      = 1'b0;
    hold       = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_wait) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          hold       = 1'b1;
          wait_d     = '0;
          state_d    = MEMWAIT;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          bubble     = 1'b1;
          state_d    = LDSTALL;
        end else if (hz.Branch_taken_i) begin
          flush      = 1'b1;
        end
      end
      // The bubble is already in EX, so load-use is not re-evaluated here.
      LDSTALL: begin
        if (mem_wait) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          hold       = 1'b1;
          wait_d     = '0;
          state_d    = MEMWAIT;
        end else begin
          state_d    = RUN;
        end
      end
      // Leave as soon as the ack shows up; its cycle already runs unstalled.
      MEMWAIT: begin
        if (hz.dmem_ack_i) begin
          state_d    = RUN;
        end else begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          hold       = 1'b1;
          wait_d     = wait_q + WAIT_W'(1);
          if (wait_d == WAIT_LIMIT) begin
            state_d   = ERROR;
            timeout_d = 1'b1;
          end
        end
      end
      ERROR: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        hold       = 1'b1;
        bubble     = 1'b1;
      end
      default: begin
        state_d    = RUN;
      end
    endcase

    if (!rst_i) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      bubble     = 1'b0;
      flush      = 1'b0;
      hold       = 1'b0;
    end
  end

  assign stall_inc = ~pc_write;

  sat_counter #(
    .DATA_W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (stall_inc),
    .count (hz.stall_cnt_o)
  );

  assign hz.PCWrite_o     = pc_write;
  assign hz.IFIDWrite_o   = ifid_write;
  assign hz.IDEX_Bubble_o = bubble;
  assign hz.IFID_Flush_o  = flush;
  assign hz.Pipe_Hold_o   = hold;
  assign hz.timeout_o     = timeout_q;
  assign hz.state_o       = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  hazard_ctrl_if hif();

  hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .hz    (hif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: mode 0 running, 1 just bubbled, 2 waiting on
  // memory, 3 dead until reset. m_wait counts waiting cycles seen.
  int m_mode  = 0;
  int m_wait  = 0;
  int m_stall = 0;
  bit m_to    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit f_mw();
    return (hif.dmem_req_i == 1'b1) && (hif.dmem_ack_i == 1'b0);
  endfunction

  function automatic bit f_lu();
    int rd;
    rd = int'(hif.IDEX_Rd_i);
    return hif.IDEX_MemRead_i && (rd != 0) &&
           (rd == int'(hif.IFID_Rs1_i) || rd == int'(hif.IFID_Rs2_i));
  endfunction

  // Expected {PCWrite, IFIDWrite, Bubble, Flush, Hold} for this cycle.
  function automatic logic [4:0] exp_ctrl();
    bit front_stop;
    bit bub;
    bit fl;
    bit hld;
    front_stop = 1'b0;
    bub        = 1'b0;
    fl         = 1'b0;
    hld        = 1'b0;
    if (rst_n) begin
      if (m_mode == 3) begin
        front_stop = 1'b1; hld = 1'b1; bub = 1'b1;
      end else if (m_mode == 2) begin
        if (!hif.dmem_ack_i) begin
          front_stop = 1'b1; hld = 1'b1;
        end
      end else if (f_mw()) begin
        front_stop = 1'b1; hld = 1'b1;
      end else if (m_mode == 0 && f_lu()) begin
        front_stop = 1'b1; bub = 1'b1;
      end else if (m_mode == 0) begin
        fl = hif.Branch_taken_i;
      end
    end
    return {!front_stop, !front_stop, bub, fl, hld};
  endfunction

  logic [4:0] m_ctrl;

  // Advance the model on each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= 0;
      m_wait  <= 0;
      m_stall <= 0;
      m_to    <= 1'b0;
    end else begin
      m_ctrl = exp_ctrl();
      if (!m_ctrl[4] && m_stall < 65535) m_stall <= m_stall + 1;
      if (m_mode == 0 || m_mode == 1) begin
        if (f_mw()) begin
          m_mode <= 2;
          m_wait <= 0;
        end else if (m_mode == 0 && f_lu()) begin
          m_mode <= 1;
        end else begin
          m_mode <= 0;
        end
      end else if (m_mode == 2) begin
        if (hif.dmem_ack_i) begin
          m_mode <= 0;
        end else begin
          m_wait <= m_wait + 1;
          if (m_wait + 1 == MEM_TIMEOUT) begin
            m_mode <= 3;
            m_to   <= 1'b1;
          end
        end
      end
    end
  end

  logic [4:0] c_ctrl;

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    c_ctrl = exp_ctrl();
    check("cycle",
          32'({hif.PCWrite_o, hif.IFIDWrite_o, hif.IDEX_Bubble_o, hif.IFID_Flush_o,
               hif.Pipe_Hold_o, hif.state_o, hif.timeout_o, hif.stall_cnt_o}),
          32'({c_ctrl, 2'(m_mode), m_to, 16'(m_stall)}));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit br, input bit req, input bit ack);
    hif.IDEX_MemRead_i = mr;
    hif.IDEX_Rd_i      = rd;
    hif.IFID_Rs1_i     = rs1;
    hif.IFID_Rs2_i     = rs2;
    hif.Branch_taken_i = br;
    hif.dmem_req_i     = req;
    hif.dmem_ack_i     = ack;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  int holds;

  initial begin
    idle();
    #1 rst_n = 1'b0;
    #2;
    check("rst_state", 32'(hif.state_o), 32'd0);
    check("rst_pcwrite", 32'(hif.PCWrite_o), 32'd1);
    check("rst_stall_cnt", 32'(hif.stall_cnt_o), 32'd0);
    check("rst_timeout", 32'(hif.timeout_o), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Load-use on rs1.
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_pcwrite", 32'(hif.PCWrite_o), 32'd0);
    check("lu_bubble", 32'(hif.IDEX_Bubble_o), 32'd1);
    cyc();
    idle();
    @(negedge clk);
    check("lu_ldstall_state", 32'(hif.state_o), 32'd1);
    check("lu_ldstall_pcwrite", 32'(hif.PCWrite_o), 32'd1);
    cyc();
    @(negedge clk);
    check("lu_back_run", 32'(hif.state_o), 32'd0);
    check("lu_stall_cnt", 32'(hif.stall_cnt_o), 32'd1);

    // x0 destination never stalls.
    do_reset();
    drive(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("x0_pcwrite", 32'(hif.PCWrite_o), 32'd1);
    check("x0_bubble", 32'(hif.IDEX_Bubble_o), 32'd0);
    cyc();
    idle();
    @(negedge clk);
    check("x0_stall_cnt", 32'(hif.stall_cnt_o), 32'd0);

    // Memory wait: three ack-less cycles, then ack.
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    holds = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) hif.dmem_ack_i = 1'b1;
      @(negedge clk);
      if (hif.Pipe_Hold_o) holds++;
      cyc();
    end
    idle();
    @(negedge clk);
    check("mw_hold_cycles", 32'(holds), 32'd3);
    check("mw_state", 32'(hif.state_o), 32'd0);
    check("mw_stall_cnt", 32'(hif.stall_cnt_o), 32'd3);

    // All three events at once: memory wait wins.
    do_reset();
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("sim_flush", 32'(hif.IFID_Flush_o), 32'd0);
    check("sim_bubble", 32'(hif.IDEX_Bubble_o), 32'd0);
    check("sim_hold", 32'(hif.Pipe_Hold_o), 32'd1);
    cyc();
    hif.dmem_ack_i = 1'b1;
    @(negedge clk);
    check("sim_memwait_state", 32'(hif.state_o), 32'd2);
    check("sim_ack_pcwrite", 32'(hif.PCWrite_o), 32'd1);
    check("sim_ack_flush", 32'(hif.IFID_Flush_o), 32'd0);
    cyc();
    @(negedge clk);
    check("sim_pending_lu_bubble", 32'(hif.IDEX_Bubble_o), 32'd1);
    cyc();
    idle();
    @(negedge clk);
    check("sim_pending_lu_state", 32'(hif.state_o), 32'd1);

    // Randomized traffic with occasional one-cycle resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      cyc();
    end
    rst_n = 1'b1;

    // Timeout: ack never arrives.
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (MEM_TIMEOUT) cyc();
    @(negedge clk);
    check("to_not_yet_state", 32'(hif.state_o), 32'd2);
    check("to_not_yet_flag", 32'(hif.timeout_o), 32'd0);
    cyc();
    @(negedge clk);
    check("to_state", 32'(hif.state_o), 32'd3);
    check("to_flag", 32'(hif.timeout_o), 32'd1);
    check("to_bubble", 32'(hif.IDEX_Bubble_o), 32'd1);
    cyc();
    rst_n = 1'b0;
    #1;
    check("to_rst_state", 32'(hif.state_o), 32'd0);
    check("to_rst_flag", 32'(hif.timeout_o), 32'd0);
    check("to_rst_pcwrite", 32'(hif.PCWrite_o), 32'd1);
    check("to_rst_hold", 32'(hif.Pipe_Hold_o), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    check("to_after_rst_pcwrite", 32'(hif.PCWrite_o), 32'd1);
    check("to_after_rst_state", 32'(hif.state_o), 32'd0);

    // Saturation: park in the error state for 70000 cycles.
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (70000) cyc();
    @(negedge clk);
    check("sat_stall_cnt", 32'(hif.stall_cnt_o), 32'h0000FFFF);
    check("sat_state", 32'(hif.state_o), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
